// File: rtl/button_conditioner.sv
// Push-button front end: 2-flop synchroniser, debounce FSM, and auto-repeat.
// Emits clean one-cycle press, release and step pulses plus a debounced level.
module button_conditioner #(
    parameter int CNT_W           = 25,
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button_n,
    output logic       pressed,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       step_pulse,
    output logic [1:0] dbg_state_o
);

    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    if (DEBOUNCE_CYCLES < 2 || longint'(DEBOUNCE_CYCLES) > CNT_MAX ||
        REPEAT_DELAY < 2 || longint'(REPEAT_DELAY) > CNT_MAX ||
        REPEAT_RATE < 2 || longint'(REPEAT_RATE) > CNT_MAX ||
        REPEAT_EN < 0 || REPEAT_EN > 1) begin : g_param_err
        $error("button_conditioner: count parameter out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        S_RELEASED     = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_HELD         = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    state_t           state_q;
    logic             sync1_q;
    logic             sync_n_q;
    logic [CNT_W-1:0] deb_cnt_q;
    logic [CNT_W-1:0] rpt_cnt_q;
    logic             rpt_first_q;
    logic             pressed_q;
    logic             press_q;
    logic             release_q;
    logic             step_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 1'b1;
            sync_n_q    <= 1'b1;
            state_q     <= S_RELEASED;
            deb_cnt_q   <= '0;
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
            pressed_q   <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            step_q      <= 1'b0;
        end else begin
            sync1_q   <= button_n;
            sync_n_q  <= sync1_q;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            step_q    <= 1'b0;
            case (state_q)
                S_RELEASED: begin
                    if (!sync_n_q) begin
                        state_q   <= S_PRESS_WAIT;
                        deb_cnt_q <= CNT_W'(1);
                    end
                end
                S_PRESS_WAIT: begin
                    if (sync_n_q) begin
                        state_q   <= S_RELEASED;
                        deb_cnt_q <= '0;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        state_q     <= S_HELD;
                        deb_cnt_q   <= '0;
                        rpt_cnt_q   <= '0;
                        rpt_first_q <= 1'b1;
                        pressed_q   <= 1'b1;
                        press_q     <= 1'b1;
                        step_q      <= 1'b1;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + CNT_W'(1);
                    end
                end
                S_HELD: begin
                    if (sync_n_q) begin
                        state_q   <= S_RELEASE_WAIT;
                        deb_cnt_q <= CNT_W'(1);
                        rpt_cnt_q <= '0;
                    end else if (REPEAT_EN != 0) begin
                        // First repeat waits the long delay, later ones the short rate.
                        if (rpt_cnt_q == (rpt_first_q ? DELAY_LAST : RATE_LAST)) begin
                            rpt_cnt_q   <= '0;
                            rpt_first_q <= 1'b0;
                            step_q      <= 1'b1;
                        end else begin
                            rpt_cnt_q <= rpt_cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_RELEASE_WAIT: begin
                    if (!sync_n_q) begin
                        state_q     <= S_HELD;
                        deb_cnt_q   <= '0;
                        rpt_cnt_q   <= '0;
                        rpt_first_q <= 1'b1;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        state_q   <= S_RELEASED;
                        deb_cnt_q <= '0;
                        pressed_q <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q   <= S_RELEASED;
                    deb_cnt_q <= '0;
                    rpt_cnt_q <= '0;
                    pressed_q <= 1'b0;
                end
            endcase
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign step_pulse    = step_q;
    assign dbg_state_o   = state_q;

endmodule
